// File: rtl/wb_daq_dma_engine_if.sv
// Wishbone classic write-master bundle for the DAQ DMA engine.
// Master modport drives the cycle; slave modport returns ack/err/rty.
interface wb_daq_dma_engine_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   wb_adr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW/8-1:0] wb_sel_o;
    logic            wb_we_o;
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic [2:0]      wb_cti_o;
    logic [1:0]      wb_bte_o;
    logic [DW-1:0]   wb_dat_i;
    logic            wb_ack_i;
    logic            wb_err_i;
    logic            wb_rty_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );
endinterface

// File: rtl/wb_daq_dma_engine.sv
// Round-robin DMA of per-channel words into circular buffers over Wishbone; one write per two cycles at best.
// Stalls in BUS until ack/err/rty; optional ack watchdog enabled by macro WB_DAQ_DMA_TIMEOUT_EN.
module wb_daq_dma_engine #(
    parameter int NUM_CH  = 4,
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255,
    localparam int GW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    wb_clk,
    input  logic                    wb_rst_n,
    input  logic [NUM_CH-1:0]       ch_enable_i,
    input  logic [NUM_CH-1:0]       ch_req_i,
    input  logic [NUM_CH*DW-1:0]    ch_data_i,
    input  logic [NUM_CH*AW-1:0]    ch_base_i,
    input  logic [NUM_CH*LEN_W-1:0] ch_len_i,
    output logic [NUM_CH-1:0]       ch_ack_o,
    output logic [NUM_CH-1:0]       ch_wrap_o,
    output logic [NUM_CH-1:0]       ch_err_o,
    output logic [GW-1:0]           grant_o,
    output logic                    busy_o,
    wb_daq_dma_engine_if.master     wb
);
    localparam int BYTES = DW / 8;

    typedef enum logic [1:0] {IDLE, BUS, RETRY} state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [AW-1:0]       adr_q, adr_d;
    logic [DW-1:0]       dat_q, dat_d;
    logic [BYTES-1:0]    sel_q, sel_d;
    logic                cyc_q, cyc_d;
    logic                stb_q, stb_d;
    logic                we_q, we_d;
    logic [NUM_CH-1:0]   ack_q, ack_d;
    logic [NUM_CH-1:0]   wrap_q, wrap_d;
    logic [NUM_CH-1:0]   err_q, err_d;
    logic [LEN_W-1:0]    offset_q [NUM_CH];
    logic [LEN_W-1:0]    offset_d [NUM_CH];

    logic [NUM_CH-1:0]   elig;
    logic                found;
    logic [GW-1:0]       pick;
    logic [GW-1:0]       cand;
    logic [LEN_W:0]      nxt_off;
    logic [LEN_W:0]      cur_len;
    logic                tmo_hit;
    logic [DW-1:0]       unused_dat;

    assign unused_dat = wb.wb_dat_i;

`ifdef WB_DAQ_DMA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    assign tmo_hit = (state_q == BUS) && (tmo_q >= TW'(TIMEOUT - 1));
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        elig = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            elig[k] = ch_enable_i[k] & ch_req_i[k] & ~err_q[k] &
                      (ch_len_i[k*LEN_W +: LEN_W] != '0);
        end
    end

    // Search starts one past the last grant so every eligible channel gets a turn.
    always_comb begin
        found = 1'b0;
        pick  = grant_q;
        cand  = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = GW'((int'(grant_q) + i) % NUM_CH);
            if (!found && elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        we_d     = we_q;
        ack_d    = '0;
        wrap_d   = '0;
        err_d    = err_q;
        offset_d = offset_q;
        cur_len  = {1'b0, ch_len_i[grant_q*LEN_W +: LEN_W]};
        nxt_off  = {1'b0, offset_q[grant_q]} + (LEN_W+1)'(1);
`ifdef WB_DAQ_DMA_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    adr_d   = ch_base_i[pick*AW +: AW] + AW'(offset_q[pick]) * AW'(BYTES);
                    dat_d   = ch_data_i[pick*DW +: DW];
                    sel_d   = '1;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = 1'b1;
                    state_d = BUS;
`ifdef WB_DAQ_DMA_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            BUS: begin
`ifdef WB_DAQ_DMA_TIMEOUT_EN
                tmo_d = tmo_q + TW'(1);
`endif
                if (wb.wb_err_i || (tmo_hit && !wb.wb_ack_i && !wb.wb_rty_i)) begin
                    err_d[grant_q] = 1'b1;
                    ack_d[grant_q] = 1'b1;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = IDLE;
                end else if (wb.wb_ack_i) begin
                    ack_d[grant_q] = 1'b1;
                    // Compare against len, not len-1, so a shrunk buffer wraps instead of overrunning.
                    if (nxt_off >= cur_len) begin
                        offset_d[grant_q] = '0;
                        wrap_d[grant_q]   = 1'b1;
                    end else begin
                        offset_d[grant_q] = nxt_off[LEN_W-1:0];
                    end
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = IDLE;
                end else if (wb.wb_rty_i) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = RETRY;
                end
            end
            RETRY: begin
`ifdef WB_DAQ_DMA_TIMEOUT_EN
                tmo_d   = '0;
`endif
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
                we_d    = 1'b1;
                state_d = BUS;
            end
            default: state_d = IDLE;
        endcase
        // Disable wins over any completion update in the same cycle.
        for (int k = 0; k < NUM_CH; k++) begin
            if (!ch_enable_i[k]) begin
                offset_d[k] = '0;
                err_d[k]    = 1'b0;
            end
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= IDLE;
            grant_q <= GW'(NUM_CH - 1);
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            ack_q   <= '0;
            wrap_q  <= '0;
            err_q   <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                offset_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            we_q     <= we_d;
            ack_q    <= ack_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
            offset_q <= offset_d;
        end
    end

`ifdef WB_DAQ_DMA_TIMEOUT_EN
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_sel_o = sel_q;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = stb_q;
    assign wb.wb_cti_o = 3'b000;
    assign wb.wb_bte_o = 2'b00;
    assign ch_ack_o    = ack_q;
    assign ch_wrap_o   = wrap_q;
    assign ch_err_o    = err_q;
    assign grant_o     = grant_q;
    assign busy_o      = cyc_q;
endmodule
